// File: rtl/alu_exec_stage.sv
// Execute/writeback stage around an external combinational ALU.
// Owns the architectural register file, status flags and retire counter.
module alu_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int OPSEL_W = 6,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic [OPSEL_W-1:0] in_opsel,
  input  logic [ADDR_W-1:0]  in_rd,
  input  logic [ADDR_W-1:0]  in_rs1,
  input  logic [ADDR_W-1:0]  in_rs2,
  input  logic               in_use_imm,
  input  logic [DATA_W-1:0]  in_imm,
  output logic [DATA_W-1:0]  op_a,
  output logic [DATA_W-1:0]  op_b,
  output logic [OPSEL_W-1:0] alu_opsel,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               ovf_flag,
  input  logic               cf_flag,
  input  logic               zero_flag,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic [2:0]         flags_q,
  output logic [15:0]        retire_cnt,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];

  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [2:0]        flags_d;
  logic [15:0]       retire_cnt_q, retire_cnt_d;

  logic              accept;
  logic [DATA_W-1:0] src_a, src_b;

  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign alu_opsel = in_opsel;

  // Operand fetch: r0 is hard zero, then the uncommitted writeback wins over the array.
  always_comb begin
    src_a = rf_q[in_rs1];
    if (wb_valid_q && (wb_rd_q == in_rs1)) src_a = wb_data_q;
    if (in_rs1 == '0) src_a = '0;

    src_b = rf_q[in_rs2];
    if (wb_valid_q && (wb_rd_q == in_rs2)) src_b = wb_data_q;
    if (in_rs2 == '0) src_b = '0;

    op_a = src_a;
    op_b = in_use_imm ? in_imm : src_b;
  end

  always_comb begin
    wb_valid_d   = accept;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    flags_d      = flags_q;
    retire_cnt_d = retire_cnt_q;
    if (accept) begin
      wb_rd_d      = in_rd;
      wb_data_d    = alu_result;
      flags_d      = {ovf_flag, cf_flag, zero_flag};
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  // Commit reads the current writeback register, so it coexists with a new accept.
  always_comb begin
    rf_d = rf_q;
    if (wb_valid_q && (wb_rd_q != '0)) rf_d[wb_rd_q] = wb_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      flags_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      rf_q         <= rf_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      flags_q      <= flags_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign retire_cnt = retire_cnt_q;
  assign dbg_data   = rf_q[dbg_addr];

endmodule
